// File: rtl/famicom_bus_initiator.sv
// Famicom CPU-side bus initiator: queues read/write commands and replays them
// as M2-timed bus cycles with /ROMSEL decode, read responses and a latched cart IRQ.
package famicom_bus_initiator_pkg;
  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;
endpackage

module famicom_bus_initiator
  import famicom_bus_initiator_pkg::*;
#(
  parameter int unsigned M2_LOW     = 4,
  parameter int unsigned M2_HIGH    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        irq_n,
  input  logic        irq_clear,
  output logic        irq_pending,
  output logic        busy
);

  localparam int unsigned PERIOD = M2_LOW + M2_HIGH;
  localparam int unsigned CW     = $clog2(PERIOD);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned NW     = $clog2(FIFO_DEPTH + 1);

  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [NW-1:0] count, count_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cur_vld, cur_vld_nxt;
  logic          cur_rw, cur_rw_nxt;
  logic          cur_hi, cur_hi_nxt;
  logic [7:0]    cur_wdata, cur_wdata_nxt;
  logic [1:0]    irq_sync;
  cmd_t          head;
  logic          start, push, pop;

  logic          cmd_ready_nxt, rsp_valid_nxt, m2_nxt, romsel_nxt, cpu_rw_nxt;
  logic          cpu_data_oe_nxt, irq_pending_nxt, busy_nxt;
  logic [7:0]    rsp_rdata_nxt, cpu_data_out_nxt;
  logic [14:0]   cpu_addr_nxt;

  // Next-state and next-output logic; everything is registered below.
  always_comb begin
    cnt_nxt          = (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
    start            = (cnt_nxt == '0);
    head             = mem[rd_ptr];
    push             = cmd_valid && cmd_ready;
    pop              = start && (count != '0);
    count_nxt        = count + NW'(push) - NW'(pop);
    wr_ptr_nxt       = push ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_nxt       = pop ? rd_ptr + AW'(1) : rd_ptr;
    cur_vld_nxt      = cur_vld;
    cur_rw_nxt       = cur_rw;
    cur_hi_nxt       = cur_hi;
    cur_wdata_nxt    = cur_wdata;
    cpu_rw_nxt       = cpu_rw;
    cpu_addr_nxt     = cpu_addr;
    cpu_data_out_nxt = cpu_data_out;
    rsp_rdata_nxt    = rsp_rdata;

    // A bus cycle latches its command (or an idle cycle) at the first LOW clk.
    if (start) begin
      cur_vld_nxt   = pop;
      cur_rw_nxt    = pop ? head.rw : 1'b1;
      cur_hi_nxt    = pop ? head.addr[15] : 1'b0;
      cur_wdata_nxt = pop ? head.wdata : 8'h00;
      cpu_rw_nxt    = pop ? head.rw : 1'b1;
      cpu_addr_nxt  = pop ? head.addr[14:0] : 15'h0000;
    end

    m2_nxt     = (cnt_nxt >= CW'(M2_LOW));
    romsel_nxt = !(m2_nxt && cur_vld_nxt && cur_hi_nxt);

    // Write data is driven through HIGH and held one clk past the M2 fall.
    cpu_data_oe_nxt = (m2_nxt && cur_vld_nxt && !cur_rw_nxt) ||
                      (start && cur_vld && !cur_rw);
    if ((cnt_nxt == CW'(M2_LOW)) && cur_vld_nxt && !cur_rw_nxt)
      cpu_data_out_nxt = cur_wdata_nxt;

    // Read data is captured at the end of the last HIGH clk.
    rsp_valid_nxt = start && cur_vld && cur_rw;
    if (rsp_valid_nxt)
      rsp_rdata_nxt = cpu_data_in;

    busy_nxt        = (count_nxt != '0) || cur_vld_nxt || (start && cur_vld);
    cmd_ready_nxt   = (count_nxt != NW'(FIFO_DEPTH));
    irq_pending_nxt = !irq_sync[1] ? 1'b1 : (irq_clear ? 1'b0 : irq_pending);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= CW'(PERIOD - 1);
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      cur_vld      <= 1'b0;
      cur_rw       <= 1'b1;
      cur_hi       <= 1'b0;
      cur_wdata    <= 8'h00;
      irq_sync     <= 2'b11;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      m2           <= 1'b0;
      romsel       <= 1'b1;
      cpu_rw       <= 1'b1;
      cpu_addr     <= 15'h0000;
      cpu_data_out <= 8'h00;
      cpu_data_oe  <= 1'b0;
      irq_pending  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      cur_vld      <= cur_vld_nxt;
      cur_rw       <= cur_rw_nxt;
      cur_hi       <= cur_hi_nxt;
      cur_wdata    <= cur_wdata_nxt;
      irq_sync     <= {irq_sync[0], irq_n};
      cmd_ready    <= cmd_ready_nxt;
      rsp_valid    <= rsp_valid_nxt;
      rsp_rdata    <= rsp_rdata_nxt;
      m2           <= m2_nxt;
      romsel       <= romsel_nxt;
      cpu_rw       <= cpu_rw_nxt;
      cpu_addr     <= cpu_addr_nxt;
      cpu_data_out <= cpu_data_out_nxt;
      cpu_data_oe  <= cpu_data_oe_nxt;
      irq_pending  <= irq_pending_nxt;
      busy         <= busy_nxt;
    end
  end

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
  end

endmodule

// File: tb/tb_famicom_bus_initiator.sv
// Directed bench for famicom_bus_initiator at default timing (4 LOW / 4 HIGH, depth 4).
module tb_famicom_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata, rsp_rdata, cpu_data_out, cpu_data_in;
  logic        rsp_valid, m2, romsel, cpu_rw, cpu_data_oe;
  logic [14:0] cpu_addr;
  logic        irq_n, irq_clear, irq_pending, busy;

  int t;
  int n_vec = 0;
  int n_err = 0;

  famicom_bus_initiator dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .m2(m2), .romsel(romsel),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in), .irq_n(irq_n),
    .irq_clear(irq_clear), .irq_pending(irq_pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic tick_to(input int target);
    while (t < target) tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m2"}, m2, 0);
    check({tag, "_romsel"}, romsel, 1);
    check({tag, "_rw"}, cpu_rw, 1);
    check({tag, "_addr"}, cpu_addr, 0);
    check({tag, "_dout"}, cpu_data_out, 0);
    check({tag, "_oe"}, cpu_data_oe, 0);
    check({tag, "_rspv"}, rsp_valid, 0);
    check({tag, "_rdata"}, rsp_rdata, 0);
    check({tag, "_irq"}, irq_pending, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, cmd_ready, 0);
  endtask

  logic        cr [5];
  logic [15:0] ca [5];
  logic [7:0]  cw [5];
  logic [15:0] a;
  int nlow, npulse;

  initial begin
    cr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ca = '{16'h6000, 16'hC123, 16'h8001, 16'h4020, 16'hFFFF};
    cw = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h33};
    t = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 16'h0;
    cmd_wdata = 8'h0; cpu_data_in = 8'h0; irq_n = 1'b1; irq_clear = 1'b0;

    tick(3);
    check_reset_outputs("por");
    rst_n = 1'b1;
    tick(1);
    t = 0;
    check("ready_after_rel", cmd_ready, 1);

    // Idle bus: 10 cycles of m2 toggling every 4 clks with nothing asserted.
    for (int i = 0; i < 80; i++) begin
      check("idle_m2", m2, ((i % 8) >= 4) ? 1 : 0);
      check("idle_rw", cpu_rw, 1);
      check("idle_romsel", romsel, 1);
      check("idle_busy", busy, 0);
      tick(1);
    end

    // Write $5006 = $04, popped at t=88.
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h5006; cmd_wdata = 8'h04;
    tick(1);
    cmd_valid = 1'b0;
    check("wr_busy_queued", busy, 1);
    tick_to(88);
    check("wr_rw", cpu_rw, 0);
    check("wr_addr", cpu_addr, 15'h5006);
    check("wr_oe_low", cpu_data_oe, 0);
    for (int i = 88; i < 96; i++) begin
      check("wr_romsel", romsel, 1);
      check("wr_rsp", rsp_valid, 0);
      check("wr_rw_hold", cpu_rw, 0);
      if (i == 92) begin
        check("wr_oe_high", cpu_data_oe, 1);
        check("wr_dout", cpu_data_out, 8'h04);
        check("wr_m2_high", m2, 1);
      end
      tick(1);
    end
    check("wr_hold_oe", cpu_data_oe, 1);
    check("wr_hold_dout", cpu_data_out, 8'h04);
    check("wr_hold_m2", m2, 0);
    check("wr_hold_busy", busy, 1);
    check("wr_hold_rsp", rsp_valid, 0);
    tick(1);
    check("wr_oe_off", cpu_data_oe, 0);
    check("wr_busy_off", busy, 0);

    // Read $8000, bus returns $A5 only during the last HIGH clk.
    cpu_data_in = 8'h3C;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 16'h8000;
    tick(1);
    cmd_valid = 1'b0;
    tick_to(104);
    nlow = 0; npulse = 0;
    for (int i = 104; i < 120; i++) begin
      if (romsel == 1'b0) nlow++;
      if (rsp_valid == 1'b1) npulse++;
      if (i == 104) check("rd_rw", cpu_rw, 1);
      if (i == 108) check("rd_romsel", romsel, 0);
      check("rd_oe", cpu_data_oe, 0);
      if (i == 111) cpu_data_in = 8'hA5;
      if (i == 112) begin
        cpu_data_in = 8'h00;
        check("rd_rspv", rsp_valid, 1);
        check("rd_rdata", rsp_rdata, 8'hA5);
        check("rd_rsp_m2", m2, 0);
      end
      if (i == 113) begin
        check("rd_rspv_off", rsp_valid, 0);
        check("rd_rdata_hold", rsp_rdata, 8'hA5);
      end
      tick(1);
    end
    check("rd_romsel_clks", nlow, 4);
    check("rd_pulses", npulse, 1);

    // Five back-to-back commands into a depth-4 FIFO.
    for (int k = 0; k < 4; k++) begin
      cmd_valid = 1'b1; cmd_rw = cr[k]; cmd_addr = ca[k]; cmd_wdata = cw[k];
      check("burst_ready", cmd_ready, 1);
      tick(1);
    end
    cmd_rw = cr[4]; cmd_addr = ca[4]; cmd_wdata = cw[4];
    while (t < 128) begin
      check("burst_full", cmd_ready, 0);
      tick(1);
    end
    check("burst_ready_pop", cmd_ready, 1);
    tick(1);
    cmd_valid = 1'b0;
    check("burst_refull", cmd_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick_to(132 + 8 * k);
      a = ca[k];
      check("burst_rw", cpu_rw, cr[k]);
      check("burst_addr", cpu_addr, a[14:0]);
      check("burst_romsel", romsel, !a[15]);
      check("burst_oe", cpu_data_oe, !cr[k]);
      if (!cr[k]) check("burst_dout", cpu_data_out, cw[k]);
      cpu_data_in = 8'(8'h40 + k);
      tick_to(136 + 8 * k);
      check("burst_rspv", rsp_valid, cr[k]);
      if (cr[k]) check("burst_rdata", rsp_rdata, 8'(8'h40 + k));
    end
    check("burst_busy_hold", busy, 1);
    tick(1);
    check("burst_busy_off", busy, 0);

    // Reset during the HIGH phase of a read to $C000.
    tick_to(176);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 16'hC000;
    tick(1);
    cmd_valid = 1'b0;
    tick_to(189);
    check("rst_pre_romsel", romsel, 0);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    t = 0;
    check("midrst_ready", cmd_ready, 1);
    for (int i = 0; i < 24; i++) begin
      check("midrst_m2", m2, ((i % 8) >= 4) ? 1 : 0);
      check("midrst_rspv", rsp_valid, 0);
      check("midrst_busy", busy, 0);
      tick(1);
    end

    // IRQ: a 1-clk low pulse latches after the synchronizer; set beats clear.
    irq_n = 1'b0;
    tick(1);
    irq_n = 1'b1;
    tick(1);
    check("irq_sync_lag", irq_pending, 0);
    tick(1);
    check("irq_set", irq_pending, 1);
    tick(3);
    check("irq_latched", irq_pending, 1);
    irq_clear = 1'b1;
    tick(1);
    irq_clear = 1'b0;
    check("irq_cleared", irq_pending, 0);
    irq_n = 1'b0;
    tick(3);
    check("irq_reset_again", irq_pending, 1);
    irq_clear = 1'b1;
    tick(2);
    check("irq_set_wins", irq_pending, 1);
    irq_n = 1'b1;
    tick(2);
    check("irq_set_wins_sync", irq_pending, 1);
    tick(1);
    check("irq_release", irq_pending, 0);
    irq_clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/famicom_bus_initiator.md
FAMICOM_BUS_INITIATOR -- requirements
Module: famicom_bus_initiator

Interface
REQ-001 SHALL have parameter M2_LOW, default 4, meaning clk cycles per M2-low phase (legal range 2..15).
REQ-002 SHALL have parameter M2_HIGH, default 4, meaning clk cycles per M2-high phase (legal range 2..15).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the command FIFO depth (power of two, at least 2).
REQ-004 SHALL have ports as follows; the block SHALL use one clock, and reset SHALL be synchronous and active-low:
  clk  in  1  system clock, all logic on rising edge
  rst_n  in  1  synchronous active-low reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  FIFO can accept
  cmd_rw  in  1  1=read, 0=write
  cmd_addr  in  16  CPU address $0000-$FFFF
  cmd_wdata  in  8  write data
  rsp_valid  out  1  one-clk pulse, read data valid
  rsp_rdata  out  8  read data
  m2  out  1  CPU M2 phase clock
  romsel  out  1  active-low /ROMSEL
  cpu_rw  out  1  CPU R/W
  cpu_addr  out  15  CPU A14-A0
  cpu_data_out  out  8  write data to bus
  cpu_data_oe  out  1  drive enable for cpu_data_out
  cpu_data_in  in  8  bus data for reads
  irq_n  in  1  open-drain cart IRQ, asynchronous
  irq_clear  in  1  clears irq_pending
  irq_pending  out  1  latched IRQ
  busy  out  1  FIFO non-empty or a command cycle in progress

Function
REQ-005 SHALL generate a free-running bus cycle: M2_LOW clks with m2=0, then M2_HIGH clks with m2=1, repeating; all bus outputs SHALL be registered.
REQ-006 SHALL, at the first clk of each LOW phase, pop one FIFO entry if the FIFO is non-empty (command cycle); otherwise it SHALL run an idle cycle with cpu_rw=1, cpu_addr=0, and romsel high.
REQ-007 cpu_rw and cpu_addr SHALL change only at the first clk of a LOW phase and SHALL be held for the whole bus cycle; cpu_addr SHALL be cmd_addr[14:0].
REQ-008 romsel SHALL be 0 only during HIGH-phase clks of a command cycle with cmd_addr[15]=1, and SHALL be 1 otherwise.
REQ-009 For writes, cpu_data_oe SHALL be 1 and cpu_data_out SHALL be cmd_wdata from the first HIGH clk through the first LOW clk of the following cycle (one clk of hold past the m2 fall); otherwise cpu_data_oe SHALL be 0.
REQ-010 For reads, cpu_data_in SHALL be sampled on the last HIGH clk; rsp_valid SHALL pulse for exactly one clk, coincident with the first clk of m2=0, with rsp_rdata holding the sample until the next read.
REQ-011 Writes SHALL produce no rsp_valid; responses SHALL come back in command order.
REQ-012 The FIFO SHALL accept when cmd_valid&&cmd_ready; cmd_ready SHALL be !full from registered count only, so a pop does not raise cmd_ready in the same clk.
REQ-013 A simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH; cmd_valid while full SHALL be ignored with no corruption.
REQ-014 irq_n SHALL pass through a 2-flop synchronizer; irq_pending SHALL set when the synchronized value is 0 and clear on irq_clear; if set and clear occur in the same clk, set SHALL win.
REQ-015 busy SHALL be 1 while the FIFO is non-empty or a popped command has not completed its hold clk.

Reset
REQ-016 On rst_n=0 at a clk edge: m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_out=0, cpu_data_oe=0, rsp_valid=0, rsp_rdata=0, irq_pending=0, busy=0, cmd_ready=0, FIFO emptied, synchronizer=1.
REQ-017 After release: cmd_ready=1 on the next clk, and the phase counter SHALL restart at LOW clk 0; reset during an in-flight command SHALL drop it with no rsp_valid.

Verification
REQ-018 Defaults, write $5006=$04 -> romsel stays 1, cpu_rw=0, cpu_addr=$5006, oe=1 with data $04 across the m2 fall, then oe=0 one clk later.
REQ-019 Read $8000, bus returns $A5 -> romsel=0 exactly 4 clks, rsp_valid one clk at m2 fall, rsp_rdata=$A5.
REQ-020 Push 5 commands back-to-back with no cycle running -> cmd_ready=0 after 4; the 5th is held, accepted after the first pop; all 5 issue in order on consecutive bus cycles.
REQ-021 Hold irq_n=0 for 1 clk -> irq_pending=1 within 3 clks; irq_clear with irq_n=0 still asserted -> irq_pending stays 1.
REQ-022 Assert rst_n=0 during the HIGH phase of a read -> outputs match REQ-016 next clk, no rsp_valid, FIFO empty, m2 period resumes at 8 clks.
REQ-023 Empty FIFO for 10 bus cycles -> m2 toggles every 4 clks, cpu_rw=1, romsel=1, busy=0.
